// File: rtl/control_unit.sv
// Multicycle control FSM for the MIPS-subset CPU: sequences every datapath load-enable and mux-select.
// Define CU_EXCEPTION_EN to add the EXC state (bad opcode/funct and add/sub/addi overflow trap).
module control_unit #(
  parameter int SP_INIT = 227
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       zero,
  input  logic       overflow,
  output logic       PC_write,
  output logic [1:0] PCSource,
  output logic [2:0] IorD,
  output logic       MEM_wr,
  output logic       MEMRead,
  output logic       IRWrite,
  output logic       MDR_load,
  output logic       A_load,
  output logic       B_load,
  output logic       ALUOut_load,
  output logic       EPC_load,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [2:0] MenToReg,
  output logic [1:0] ALUSourceA,
  output logic [2:0] ALUSourceB,
  output logic [2:0] ALUOp,
  output logic [1:0] exc_cause,
  output logic [4:0] state
);

  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24;
  localparam logic [2:0] ALU_ADD = 3'b001, ALU_SUB = 3'b010, ALU_AND = 3'b011;

  localparam logic [4:0] S_RESET = 5'd0, S_FETCH = 5'd1, S_WAIT = 5'd2, S_IR_LD = 5'd3;
  localparam logic [4:0] S_DECODE = 5'd4, S_EXEC_R = 5'd5, S_WB_R = 5'd6, S_EXEC_I = 5'd7;
  localparam logic [4:0] S_WB_I = 5'd8, S_ADDR = 5'd9, S_MEM_RD = 5'd10, S_MEM_WAIT = 5'd11;
  localparam logic [4:0] S_MDR_LD = 5'd12, S_WB_LW = 5'd13, S_MEM_WR = 5'd14, S_BRANCH = 5'd15;
  localparam logic [4:0] S_JUMP = 5'd16;
`ifdef CU_EXCEPTION_EN
  localparam logic [4:0] S_EXC = 5'd17;
  logic [1:0] cause_d, cause_q;
`endif

  logic [4:0] state_d, state_q;
  logic       funct_ok;

  assign funct_ok = (FUNCT == F_ADD) || (FUNCT == F_SUB) || (FUNCT == F_AND);

  always_comb begin
    state_d = state_q;
`ifdef CU_EXCEPTION_EN
    cause_d = cause_q;
`endif
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = S_WAIT;
      S_WAIT:   state_d = S_IR_LD;
      S_IR_LD:  state_d = S_DECODE;
      S_DECODE: begin
`ifdef CU_EXCEPTION_EN
        state_d = S_EXC;
        cause_d = 2'd1;
`else
        state_d = S_FETCH;
`endif
        case (OPCODE)
          OP_R:        if (funct_ok) state_d = S_EXEC_R;
          OP_ADDI:     state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_BEQ:      state_d = S_BRANCH;
          OP_J:        state_d = S_JUMP;
          default:     ;
        endcase
      end
      S_EXEC_R: begin
        state_d = S_WB_R;
`ifdef CU_EXCEPTION_EN
        // AND cannot overflow, so the flag is meaningless there
        if (overflow && FUNCT != F_AND) begin
          state_d = S_EXC;
          cause_d = 2'd2;
        end
`endif
      end
      S_EXEC_I: begin
        state_d = S_WB_I;
`ifdef CU_EXCEPTION_EN
        if (overflow) begin
          state_d = S_EXC;
          cause_d = 2'd2;
        end
`endif
      end
      S_ADDR:     state_d = (OPCODE == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = S_MEM_WAIT;
      S_MEM_WAIT: state_d = S_MDR_LD;
      S_MDR_LD:   state_d = S_WB_LW;
      S_WB_R, S_WB_I, S_WB_LW, S_MEM_WR, S_BRANCH, S_JUMP: state_d = S_FETCH;
`ifdef CU_EXCEPTION_EN
      S_EXC:      state_d = S_FETCH;
`endif
      default:    state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

`ifdef CU_EXCEPTION_EN
  always_ff @(posedge clk) begin
    if (reset) cause_q <= 2'd0;
    else       cause_q <= cause_d;
  end
`endif

  always_comb begin
    PC_write = 1'b0; PCSource = 2'd0; IorD = 3'd0; MEM_wr = 1'b0; MEMRead = 1'b0;
    IRWrite = 1'b0; MDR_load = 1'b0; A_load = 1'b0; B_load = 1'b0; ALUOut_load = 1'b0;
    EPC_load = 1'b0; RegWrite = 1'b0; RegDst = 2'd0; MenToReg = 3'd0;
    ALUSourceA = 2'd0; ALUSourceB = 3'd0; ALUOp = 3'd0; exc_cause = 2'd0;
    state = reset ? 5'd0 : state_q;
    // reset masks every enable, including the one the aborted state would assert
    if (!reset) begin
      case (state_q)
        S_RESET: begin RegWrite = 1'b1; RegDst = 2'd2; MenToReg = 3'd3; end
        S_FETCH: begin
          MEMRead = 1'b1; ALUSourceB = 3'd1; ALUOp = ALU_ADD; PC_write = 1'b1;
        end
        S_WAIT:   MEMRead = 1'b1;
        S_IR_LD:  IRWrite = 1'b1;
        S_DECODE: begin
          A_load = 1'b1; B_load = 1'b1; ALUSourceB = 3'd3; ALUOp = ALU_ADD; ALUOut_load = 1'b1;
        end
        S_EXEC_R: begin
          ALUSourceA = 2'd1; ALUOut_load = 1'b1;
          ALUOp = (FUNCT == F_SUB) ? ALU_SUB : (FUNCT == F_AND) ? ALU_AND : ALU_ADD;
        end
        S_WB_R:   begin RegDst = 2'd1; RegWrite = 1'b1; end
        S_EXEC_I, S_ADDR: begin
          ALUSourceA = 2'd1; ALUSourceB = 3'd2; ALUOp = ALU_ADD; ALUOut_load = 1'b1;
        end
        S_WB_I:   RegWrite = 1'b1;
        S_MEM_RD, S_MEM_WAIT: begin IorD = 3'd3; MEMRead = 1'b1; end
        S_MDR_LD: MDR_load = 1'b1;
        S_WB_LW:  begin MenToReg = 3'd1; RegWrite = 1'b1; end
        S_MEM_WR: begin IorD = 3'd3; MEM_wr = 1'b1; end
        S_BRANCH: begin
          ALUSourceA = 2'd1; ALUOp = ALU_SUB; PC_write = zero; PCSource = 2'd1;
        end
        S_JUMP:   begin PC_write = 1'b1; PCSource = 2'd2; end
`ifdef CU_EXCEPTION_EN
        S_EXC: begin
          ALUSourceB = 3'd1; ALUOp = ALU_SUB; EPC_load = 1'b1;
          PC_write = 1'b1; PCSource = 2'd3; exc_cause = cause_q;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
